// File: rtl/mips_xlat_pkg.sv
// Definitions shared by the MIPS->RISC-V translator and its downstream instruction queue.
package mips_xlat_pkg;

    localparam logic [31:0] RV_NOP = 32'h00000013;

    typedef struct packed {
        logic        err;
        logic [31:0] instr;
    } xlat_entry_t;

    // MIPS major opcodes and SPECIAL funct codes recognised by the translator
    localparam logic [5:0] MIPS_OP_SPECIAL = 6'h00;
    localparam logic [5:0] MIPS_OP_J       = 6'h02;
    localparam logic [5:0] MIPS_OP_BEQ     = 6'h04;
    localparam logic [5:0] MIPS_OP_BNE     = 6'h05;
    localparam logic [5:0] MIPS_OP_ADDIU   = 6'h09;
    localparam logic [5:0] MIPS_OP_LUI     = 6'h0F;
    localparam logic [5:0] MIPS_OP_LW      = 6'h23;
    localparam logic [5:0] MIPS_OP_SW      = 6'h2B;
    localparam logic [5:0] MIPS_FN_SLL     = 6'h00;
    localparam logic [5:0] MIPS_FN_JR      = 6'h08;
    localparam logic [5:0] MIPS_FN_ADDU    = 6'h21;
    localparam logic [5:0] MIPS_FN_SUBU    = 6'h23;

    // Error entries carry a zeroed word so a faulting fetch never leaks into decode.
    function automatic xlat_entry_t make_entry(input logic err, input logic [31:0] instr);
        xlat_entry_t e;
        e.err   = err;
        e.instr = err ? 32'h0 : instr;
        return e;
    endfunction

endpackage

// File: rtl/mips_xlat_queue_mem.sv
// Queue storage: DEPTH entries, one synchronous write port, one asynchronous read port.
module mips_xlat_queue_mem
    import mips_xlat_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  xlat_entry_t      wr_data_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output xlat_entry_t      rd_data_o
);

    xlat_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/mips_xlat_instr_queue.sv
// Instruction queue between the MIPS->RISC-V translator and the RISC-V decode stage;
// holds translated words in order and locks out further input after an error word.
module mips_xlat_instr_queue
    import mips_xlat_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             pipe_rst_n,
    input  logic [31:0]      xlat_instr,
    input  logic             xlat_valid,
    input  logic             xlat_error,
    output logic             xlat_accepted,
    output logic [31:0]      idu_instr,
    output logic             idu_instr_vd,
    output logic             idu_instr_err,
    input  logic             idu_rdy,
    input  logic             flush,
    output logic [IDX_W:0]   q_count
);

    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [IDX_W:0]   count_q, count_d;
    logic             err_lock_q, err_lock_d;
    logic             full;
    logic             push;
    logic             pop;
    xlat_entry_t      rd_entry;

    // Accept depends only on registered state and the flush line, never on valid/ready.
    assign full          = (count_q == FULL_CNT);
    assign xlat_accepted = !full && !err_lock_q && !flush;
    assign push          = xlat_valid && xlat_accepted;
    assign idu_instr_vd  = (count_q != '0);
    assign pop           = idu_instr_vd && idu_rdy;

    mips_xlat_queue_mem #(.DEPTH(DEPTH)) u_mem (
        .clk       (clk),
        .wr_en_i   (push),
        .wr_idx_i  (wr_ptr_q),
        .wr_data_i (make_entry(xlat_error, xlat_instr)),
        .rd_idx_i  (rd_ptr_q),
        .rd_data_o (rd_entry)
    );

    assign idu_instr     = idu_instr_vd ? rd_entry.instr : RV_NOP;
    assign idu_instr_err = idu_instr_vd && rd_entry.err;
    assign q_count       = count_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_lock_d = err_lock_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            err_lock_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + IDX_W'(1);
                if (xlat_error) begin
                    err_lock_d = 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + IDX_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (IDX_W+1)'(1);
                2'b01:   count_d = count_q - (IDX_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge pipe_rst_n) begin
        if (!pipe_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_lock_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_lock_q <= err_lock_d;
        end
    end

    a_count_max: assert property (@(posedge clk) disable iff (!pipe_rst_n)
        count_q <= FULL_CNT);
    a_no_underflow: assert property (@(posedge clk) disable iff (!pipe_rst_n)
        (count_q == '0) |-> !pop);
    a_ptr_count: assert property (@(posedge clk) disable iff (!pipe_rst_n)
        (wr_ptr_q - rd_ptr_q) == count_q[IDX_W-1:0]);

endmodule

// File: tb/tb_mips_xlat_instr_queue.sv
// Directed bench for mips_xlat_instr_queue: reset, single word, fill, wrap stream, error lock, flush, async reset.
module tb_mips_xlat_instr_queue;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        pipe_rst_n;
    logic [31:0] xlat_instr;
    logic        xlat_valid;
    logic        xlat_error;
    logic        xlat_accepted;
    logic [31:0] idu_instr;
    logic        idu_instr_vd;
    logic        idu_instr_err;
    logic        idu_rdy;
    logic        flush;
    logic [2:0]  q_count;

    int tests_run = 0;
    int tests_failed = 0;

    mips_xlat_instr_queue #(.DEPTH(4)) dut (
        .clk           (clk),
        .pipe_rst_n    (pipe_rst_n),
        .xlat_instr    (xlat_instr),
        .xlat_valid    (xlat_valid),
        .xlat_error    (xlat_error),
        .xlat_accepted (xlat_accepted),
        .idu_instr     (idu_instr),
        .idu_instr_vd  (idu_instr_vd),
        .idu_instr_err (idu_instr_err),
        .idu_rdy       (idu_rdy),
        .flush         (flush),
        .q_count       (q_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then let outputs settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] words [10];
    int sent, rcvd, cyc;
    logic exp_push, exp_pop;

    initial begin
        pipe_rst_n = 1'b0;
        xlat_instr = '0;
        xlat_valid = 1'b0;
        xlat_error = 1'b0;
        idu_rdy    = 1'b0;
        flush      = 1'b0;
        tick();
        check("rst_count", 32'(q_count), 32'd0);
        check("rst_vd", 32'(idu_instr_vd), 32'd0);
        check("rst_instr", idu_instr, NOP);
        check("rst_err", 32'(idu_instr_err), 32'd0);
        check("rst_acc", 32'(xlat_accepted), 32'd1);
        pipe_rst_n = 1'b1;
        tick();

        // Single word: visible one edge after push, then popped.
        xlat_valid = 1'b1; xlat_instr = 32'h00208033;
        tick();
        xlat_valid = 1'b0;
        #1;
        check("single_vd", 32'(idu_instr_vd), 32'd1);
        check("single_instr", idu_instr, 32'h00208033);
        check("single_count", 32'(q_count), 32'd1);
        idu_rdy = 1'b1;
        tick();
        idu_rdy = 1'b0;
        check("single_pop_count", 32'(q_count), 32'd0);
        check("single_pop_instr", idu_instr, NOP);

        // Fill to DEPTH, then full refuses even with idu_rdy high.
        for (int i = 0; i < 4; i++) begin
            xlat_valid = 1'b1; xlat_instr = 32'h10000000 + 32'(i);
            tick();
        end
        xlat_valid = 1'b0;
        #1;
        check("fill_count", 32'(q_count), 32'd4);
        check("fill_acc", 32'(xlat_accepted), 32'd0);
        check("fill_head", idu_instr, 32'h10000000);
        xlat_valid = 1'b1; xlat_instr = 32'hBADBAD00; idu_rdy = 1'b1;
        #1;
        check("full_acc_rdy", 32'(xlat_accepted), 32'd0);
        tick();
        xlat_valid = 1'b0; idu_rdy = 1'b0;
        #1;
        check("after_pop_count", 32'(q_count), 32'd3);
        check("after_pop_acc", 32'(xlat_accepted), 32'd1);
        for (int i = 1; i < 4; i++) begin
            check($sformatf("drain_%0d", i), idu_instr, 32'h10000000 + 32'(i));
            idu_rdy = 1'b1;
            tick();
            idu_rdy = 1'b0;
        end
        check("drain_count", 32'(q_count), 32'd0);

        // Wrap stream: 10 words, IDU ready one cycle in three so the queue fills.
        for (int i = 0; i < 10; i++) words[i] = 32'hA0000000 + 32'(i * 16 + 3);
        sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < 10 && cyc < 100) begin
            xlat_valid = (sent < 10);
            xlat_instr = (sent < 10) ? words[sent] : 32'h0;
            idu_rdy    = (cyc % 3 == 2);
            #1;
            check($sformatf("wrap_acc_c%0d", cyc), 32'(xlat_accepted), 32'((sent - rcvd) < 4));
            check($sformatf("wrap_vd_c%0d", cyc), 32'(idu_instr_vd), 32'(sent != rcvd));
            if (sent != rcvd)
                check($sformatf("wrap_instr_%0d", rcvd), idu_instr, words[rcvd]);
            exp_push = (sent < 10) && ((sent - rcvd) < 4);
            exp_pop  = (sent != rcvd) && idu_rdy;
            tick();
            if (exp_push) sent++;
            if (exp_pop) rcvd++;
            cyc++;
        end
        xlat_valid = 1'b0; idu_rdy = 1'b0;
        check("wrap_done", 32'(rcvd), 32'd10);
        #1;
        check("wrap_count", 32'(q_count), 32'd0);

        // Error word: zeroed, flagged, and locks out further input until flush.
        xlat_valid = 1'b1; xlat_error = 1'b1; xlat_instr = 32'hDEADBEEF;
        tick();
        xlat_error = 1'b0; xlat_instr = 32'h00500293;
        #1;
        check("err_flag", 32'(idu_instr_err), 32'd1);
        check("err_instr", idu_instr, 32'h0);
        check("err_lock_acc", 32'(xlat_accepted), 32'd0);
        idu_rdy = 1'b1;
        tick();
        idu_rdy = 1'b0;
        check("err_popped_count", 32'(q_count), 32'd0);
        check("err_lock_after_pop", 32'(xlat_accepted), 32'd0);
        tick();
        check("err_refused_count", 32'(q_count), 32'd0);
        flush = 1'b1;
        #1;
        check("flush_acc", 32'(xlat_accepted), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("unlock_acc", 32'(xlat_accepted), 32'd1);
        tick();
        xlat_valid = 1'b0;
        check("unlock_count", 32'(q_count), 32'd1);
        check("unlock_instr", idu_instr, 32'h00500293);
        check("unlock_err", 32'(idu_instr_err), 32'd0);
        idu_rdy = 1'b1;
        tick();
        idu_rdy = 1'b0;

        // Flush with 3 queued while pushing and popping: everything, including the new word, is dropped.
        for (int i = 0; i < 3; i++) begin
            xlat_valid = 1'b1; xlat_instr = 32'hC0000000 + 32'(i);
            tick();
        end
        check("pre_flush_count", 32'(q_count), 32'd3);
        xlat_instr = 32'hC00000FF; idu_rdy = 1'b1; flush = 1'b1;
        #1;
        check("flush3_acc", 32'(xlat_accepted), 32'd0);
        tick();
        xlat_valid = 1'b0; idu_rdy = 1'b0; flush = 1'b0;
        #1;
        check("flush3_count", 32'(q_count), 32'd0);
        check("flush3_vd", 32'(idu_instr_vd), 32'd0);
        check("flush3_instr", idu_instr, NOP);
        xlat_valid = 1'b1; xlat_instr = 32'h00A00513;
        tick();
        xlat_valid = 1'b0;
        check("post_flush_head", idu_instr, 32'h00A00513);
        check("post_flush_count", 32'(q_count), 32'd1);

        // Asynchronous reset between edges.
        xlat_valid = 1'b1; xlat_instr = 32'h00B00593;
        tick();
        xlat_valid = 1'b0;
        #2;
        pipe_rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(q_count), 32'd0);
        check("async_rst_vd", 32'(idu_instr_vd), 32'd0);
        check("async_rst_instr", idu_instr, NOP);
        tick();
        pipe_rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
